// File: rtl/model_stream_pkg.sv
// Shared types and helpers for the model stream sequencer.
package model_stream_pkg;

  // Sequencer states: one vector walks FETCH -> ISSUE -> COLLECT -> EMIT.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_COLLECT,
    S_EMIT,
    S_DONE
  } state_e;

  // Widest entry the sentinel helper can describe.
  localparam int unsigned SENTINEL_MAX_W = 1024;

  // All-ones end-of-memory marker for an entry of the given width.
  function automatic logic [SENTINEL_MAX_W-1:0] SENTINEL_ENTRY(input int unsigned width);
    logic [SENTINEL_MAX_W-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < SENTINEL_MAX_W; i++) begin
      if (i < width) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/model_stream_ctrl.sv
// Sequencer that walks the vector memory, hands one vector at a time to the
// model over valid/ready, and re-presents each result on a result stream.
// The run ends on an all-ones entry 0 (sentinel) or after MAX_VECTORS vectors.
module model_stream_ctrl
  import model_stream_pkg::*;
#(
  parameter int unsigned       IN_W        = 32,
  parameter int unsigned       OUT_W       = 32,
  parameter int unsigned       IN_DIM      = 4,
  parameter int unsigned       OUT_DIM     = 4,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [31:0]       MAX_VECTORS = 32'd0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [IN_DIM*IN_W-1:0]     mem_data,
  output logic [IN_DIM*IN_W-1:0]     in_data,
  output logic                       in_valid,
  input  logic                       in_ready,
  input  logic [OUT_DIM*OUT_W-1:0]   out_data,
  input  logic                       out_valid,
  output logic                       out_ready,
  output logic [OUT_DIM*OUT_W-1:0]   res_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       sentinel_hit,
  output logic [31:0]                vec_count
);

  localparam logic [IN_W-1:0]   SENTINEL = IN_W'(SENTINEL_ENTRY(IN_W));
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [IN_DIM*IN_W-1:0]     in_data_q, in_data_d;
  logic [OUT_DIM*OUT_W-1:0]   res_data_q, res_data_d;
  logic [31:0]                cnt_q, cnt_d;
  logic                       sent_q, sent_d;
  logic                       in_valid_q, out_ready_q, res_valid_q;
  logic [31:0]                cnt_inc;

  // Saturating successor of the completed-vector count.
  assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  // Next-state and datapath decisions; abort overrides every transition but
  // leaves counters and captured data untouched.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    in_data_d  = in_data_q;
    res_data_d = res_data_q;
    cnt_d      = cnt_q;
    sent_d     = sent_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            addr_d  = START_ADDR;
            cnt_d   = '0;
            sent_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem_data[IN_W-1:0] == SENTINEL) begin
            sent_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            in_data_d = mem_data;
            state_d   = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (in_valid_q && in_ready) state_d = S_COLLECT;
        end
        S_COLLECT: begin
          if (out_valid) begin
            res_data_d = out_data;
            state_d    = S_EMIT;
          end
        end
        S_EMIT: begin
          if (res_ready) begin
            cnt_d   = cnt_inc;
            addr_d  = addr_q + ADDR_ONE;
            state_d = ((MAX_VECTORS != 32'd0) && (cnt_inc == MAX_VECTORS)) ? S_DONE : S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, datapath and handshake registers; handshake flags follow the next
  // state so every stream output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= START_ADDR;
      in_data_q   <= '0;
      res_data_q  <= '0;
      cnt_q       <= '0;
      sent_q      <= 1'b0;
      in_valid_q  <= 1'b0;
      out_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      in_data_q   <= in_data_d;
      res_data_q  <= res_data_d;
      cnt_q       <= cnt_d;
      sent_q      <= sent_d;
      in_valid_q  <= (state_d == S_ISSUE);
      out_ready_q <= (state_d == S_COLLECT);
      res_valid_q <= (state_d == S_EMIT);
    end
  end

  assign mem_addr     = addr_q;
  assign in_data      = in_data_q;
  assign in_valid     = in_valid_q;
  assign out_ready    = out_ready_q;
  assign res_data     = res_data_q;
  assign res_valid    = res_valid_q;
  assign sentinel_hit = sent_q;
  assign vec_count    = cnt_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_model_stream_ctrl.sv
// Self-checking bench for model_stream_ctrl: a shared vector memory, a
// behavioural model core, a run planner that derives expected vectors and
// results from memory contents, and a per-cycle compare process.
module tb_model_stream_ctrl;

  logic         clk = 1'b0;
  logic         reset, start, abort, in_ready, res_ready, model_go, stray_ov;
  logic [31:0]  mem_addr, vec_count;
  logic [127:0] mem_data, in_data, out_data, res_data;
  logic         in_valid, out_valid, out_ready, res_valid, busy, done, sentinel_hit;

  logic         lim_start;
  logic [31:0]  lim_mem_addr, lim_vec_count;
  logic [127:0] lim_mem_data, lim_in_data, lim_out_data, lim_res_data;
  logic         lim_in_valid, lim_out_ready, lim_res_valid, lim_busy, lim_done, lim_sentinel;

  logic [127:0] mem [16];
  logic [127:0] exp_in[$], exp_res[$], exp_lim[$];
  int           n_vec = 0, n_err = 0;
  int           res_seen = 0, lim_seen = 0, iv_cnt = 0;

  always #5 clk = ~clk;

  assign mem_data     = mem[mem_addr[3:0]];
  assign lim_mem_data = mem[lim_mem_addr[3:0]];

  // Model core function: entry k becomes 3*entry + k.
  function automatic logic [127:0] fmodel(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = v[k*32 +: 32] * 32'd3 + 32'(k);
    return r;
  endfunction

  function automatic logic [127:0] vec(input int i);
    return {32'(i*16+4), 32'(i*16+3), 32'(i*16+2), 32'(i*16+1)};
  endfunction

  // Behavioural model core: answers the cycle after acceptance when model_go.
  logic         pend;
  logic [127:0] held;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= 1'b0;
    else if (abort) pend <= 1'b0;
    else if (in_valid && in_ready) begin
      pend <= 1'b1;
      held <= in_data;
    end else if (out_valid && out_ready) pend <= 1'b0;
  end
  assign out_valid    = (pend && model_go) || stray_ov;
  assign out_data     = pend ? fmodel(held) : 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  assign lim_out_data = fmodel(lim_in_data);

  model_stream_ctrl #(.IN_W(32), .OUT_W(32), .IN_DIM(4), .OUT_DIM(4), .ADDR_W(32),
                      .START_ADDR(32'd0), .MAX_VECTORS(32'd0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .sentinel_hit(sentinel_hit), .vec_count(vec_count));

  model_stream_ctrl #(.IN_W(32), .OUT_W(32), .IN_DIM(4), .OUT_DIM(4), .ADDR_W(32),
                      .START_ADDR(32'd8), .MAX_VECTORS(32'd2)) u_lim (
    .clk(clk), .reset(reset), .start(lim_start), .abort(1'b0),
    .mem_addr(lim_mem_addr), .mem_data(lim_mem_data),
    .in_data(lim_in_data), .in_valid(lim_in_valid), .in_ready(1'b1),
    .out_data(lim_out_data), .out_valid(1'b1), .out_ready(lim_out_ready),
    .res_data(lim_res_data), .res_valid(lim_res_valid), .res_ready(1'b1),
    .busy(lim_busy), .done(lim_done), .sentinel_hit(lim_sentinel), .vec_count(lim_vec_count));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the planned vector/result sequences.
  always @(negedge clk) begin
    if (reset) begin
      if (in_valid) begin
        iv_cnt++;
        if (exp_in.size() == 0) check("in_valid_unexpected", 128'(in_valid), 128'(0));
        else begin
          check("in_data", in_data, exp_in[0]);
          if (in_ready) void'(exp_in.pop_front());
        end
      end
      if (res_valid) begin
        if (exp_res.size() == 0) check("res_valid_unexpected", 128'(res_valid), 128'(0));
        else begin
          check("res_data", res_data, exp_res[0]);
          if (res_ready) begin
            void'(exp_res.pop_front());
            res_seen++;
          end
        end
      end
      check("one_in_flight", 128'($countones({in_valid, out_ready, res_valid}) > 1), 128'(0));
      if (lim_res_valid) begin
        if (exp_lim.size() == 0) check("lim_res_unexpected", 128'(lim_res_valid), 128'(0));
        else begin
          check("lim_res_data", lim_res_data, exp_lim[0]);
          void'(exp_lim.pop_front());
          lim_seen++;
        end
      end
    end
  end

  // Expected run from memory contents: walk until sentinel or vector limit.
  task automatic plan(input int unsigned sa, input int unsigned maxv, input bit lim,
                      output int unsigned n, output int unsigned end_addr, output bit sent);
    int unsigned a;
    a = sa; n = 0; sent = 1'b0;
    while (n < 64) begin
      if (mem[a[3:0]][31:0] == 32'hFFFF_FFFF) begin
        sent = 1'b1;
        break;
      end
      if (lim) exp_lim.push_back(fmodel(mem[a[3:0]]));
      else begin
        exp_in.push_back(mem[a[3:0]]);
        exp_res.push_back(fmodel(mem[a[3:0]]));
      end
      n++;
      a++;
      if (maxv != 0 && n == maxv) break;
    end
    end_addr = a;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return done;
      1: return in_valid;
      2: return out_ready;
      3: return res_valid;
      4: return lim_done;
      default: return (vec_count == 32'd1);
    endcase
  endfunction

  task automatic wait_until(input int w, input int budget, input string nm, output int cyc);
    cyc = 0;
    while (!sel(w) && cyc < budget) begin
      tick();
      cyc++;
    end
    if (!sel(w)) check({nm, "_timeout"}, 128'(sel(w)), 128'(1));
  endtask

  int unsigned pn, pend_addr;
  bit          psent;
  int          cyc, seen0, iv0;
  logic [127:0] save0;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; lim_start = 1'b0;
    in_ready = 1'b1; res_ready = 1'b1; model_go = 1'b1; stray_ov = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '1;
    for (int i = 0; i < 3; i++) mem[i] = vec(i);
    for (int i = 4; i < 8; i++) mem[i] = vec(i);
    for (int i = 8; i < 13; i++) mem[i] = vec(i);
    tick(2);

    // Reset values
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_lim_mem_addr", 128'(lim_mem_addr), 128'(8));
    check("rst_in_data", in_data, 128'(0));
    check("rst_res_data", res_data, 128'(0));
    check("rst_vec_count", 128'(vec_count), 128'(0));
    check("rst_flags", 128'({in_valid, out_ready, res_valid, busy, done, sentinel_hit}), 128'(0));
    reset = 1'b1;
    tick();

    // Run 1: three vectors then sentinel, all readies high
    plan(0, 0, 1'b0, pn, pend_addr, psent);
    seen0 = res_seen;
    pulse_start();
    check("t1_fetch_busy", 128'({busy, in_valid}), 128'(2'b10));
    tick();
    check("t1_in_valid_rise", 128'(in_valid), 128'(1));
    tick();
    check("t1_collect", 128'({in_valid, out_ready}), 128'(2'b01));
    tick();
    check("t1_res_valid_rise", 128'(res_valid), 128'(1));
    check("t1_first_res_lit", res_data, 128'h0000000f_0000000b_00000007_00000003);
    wait_until(0, 100, "t1_done", cyc);
    check("t1_cycles_to_done", 128'(cyc), 128'(10));
    check("t1_vec_count", 128'(vec_count), 128'(pn));
    check("t1_vec_count_lit", 128'(vec_count), 128'(3));
    check("t1_sentinel", 128'({sentinel_hit, done, busy}), 128'({psent, 2'b10}));
    check("t1_mem_addr", 128'(mem_addr), 128'(pend_addr));
    check("t1_last_res_lit", res_data, 128'h0000006f_0000006b_00000067_00000063);
    check("t1_results", 128'(res_seen - seen0), 128'(3));

    // Run 2: vector limit of 2 starting at address 8
    plan(8, 2, 1'b1, pn, pend_addr, psent);
    lim_start = 1'b1;
    tick();
    lim_start = 1'b0;
    wait_until(4, 100, "t2_done", cyc);
    check("t2_vec_count", 128'(lim_vec_count), 128'(2));
    check("t2_sentinel", 128'(lim_sentinel), 128'(psent));
    check("t2_mem_addr", 128'(lim_mem_addr), 128'(10));
    check("t2_results", 128'(lim_seen), 128'(pn));

    // Run 3: backpressure on both streams
    in_ready = 1'b0; res_ready = 1'b0;
    plan(0, 0, 1'b0, pn, pend_addr, psent);
    seen0 = res_seen;
    pulse_start();
    wait_until(1, 20, "t3_in_valid", cyc);
    tick(5);
    in_ready = 1'b1;
    wait_until(3, 20, "t3_res_valid", cyc);
    tick(3);
    res_ready = 1'b1;
    wait_until(0, 100, "t3_done", cyc);
    check("t3_vec_count", 128'(vec_count), 128'(3));
    check("t3_results", 128'(res_seen - seen0), 128'(pn));
    check("t3_leftover", 128'(exp_in.size() + exp_res.size()), 128'(0));

    // Run 4: sentinel at the start address
    save0 = mem[0];
    mem[0] = '1;
    plan(0, 0, 1'b0, pn, pend_addr, psent);
    iv0 = iv_cnt;
    pulse_start();
    check("t4_not_done_yet", 128'(done), 128'(0));
    tick();
    check("t4_done", 128'({done, sentinel_hit}), 128'(2'b11));
    check("t4_vec_count", 128'(vec_count), 128'(0));
    check("t4_no_in_valid", 128'(iv_cnt - iv0), 128'(0));
    mem[0] = save0;

    // Run 5: abort during COLLECT of the second vector, then restart
    plan(0, 0, 1'b0, pn, pend_addr, psent);
    pulse_start();
    wait_until(5, 50, "t5_first_vec", cyc);
    model_go = 1'b0;
    wait_until(2, 20, "t5_collect", cyc);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_in.delete(); exp_res.delete();
    check("t5_abort_idle", 128'({out_ready, busy, done}), 128'(0));
    check("t5_count_hold", 128'(vec_count), 128'(1));
    check("t5_addr_hold", 128'(mem_addr), 128'(1));
    stray_ov = 1'b1;
    tick(2);
    check("t5_stray_ignored", 128'({res_valid, busy}), 128'(0));
    stray_ov = 1'b0;
    model_go = 1'b1;
    plan(0, 0, 1'b0, pn, pend_addr, psent);
    seen0 = res_seen;
    pulse_start();
    check("t5_restart", 128'({mem_addr, vec_count}), 128'(0));
    wait_until(0, 100, "t5_done", cyc);
    check("t5_results", 128'({vec_count, 32'(res_seen - seen0)}), 128'({32'd3, 32'd3}));

    // Run 6: asynchronous reset during ISSUE
    in_ready = 1'b0;
    plan(0, 0, 1'b0, pn, pend_addr, psent);
    pulse_start();
    wait_until(1, 20, "t6_issue", cyc);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_flags", 128'({in_valid, out_ready, res_valid, busy, done, sentinel_hit}), 128'(0));
    check("t6_rst_data", in_data | res_data, 128'(0));
    check("t6_rst_cnt_addr", 128'({mem_addr, vec_count}), 128'(0));
    tick();
    exp_in.delete(); exp_res.delete();
    reset = 1'b1;
    in_ready = 1'b1;
    tick();
    plan(0, 0, 1'b0, pn, pend_addr, psent);
    seen0 = res_seen;
    pulse_start();
    wait_until(3, 20, "t6_res_valid", cyc);
    check("t6_first_res_lit", res_data, 128'h0000000f_0000000b_00000007_00000003);
    wait_until(0, 100, "t6_done", cyc);
    check("t6_results", 128'({vec_count, 32'(res_seen - seen0)}), 128'({32'd3, 32'd3}));

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/model_stream_ctrl.md
# model_stream_ctrl

Synthesizable sequencer that walks an input-vector memory, feeds each vector to the `model` core over a valid/ready handshake, collects the model's result and presents it on a result stream. It replaces the free-running, address-per-clock simulation harness. It adds three things: backpressure-safe sequencing, an all-ones end-of-memory sentinel, and a vector limit. It sits between the vector `memory` (combinational read) and `model`, and runs in both simulation and FPGA builds.

## Interface
Parameters:
- `IN_W`, 32, width of one input entry (32 × IN_ENTRY_WORDCNT).
- `OUT_W`, 32, width of one output entry.
- `IN_DIM`, 4, input entries per vector.
- `OUT_DIM`, 4, output entries per vector.
- `ADDR_W`, 32, memory address width.
- `START_ADDR`, 0, first vector address.
- `MAX_VECTORS`, 0, vectors to process per run; 0 means unlimited (sentinel only).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; starts a run from IDLE or DONE.
- `abort`  in  1  synchronous; returns the block to IDLE from any state.
- `mem_addr`  out  ADDR_W  vector address to `memory`.
- `mem_data`  in  IN_DIM*IN_W  combinational read data; entry 0 is in the LSBs.
- `in_data`  out  IN_DIM*IN_W  vector to model.
- `in_valid`  out  1  vector valid.
- `in_ready`  in  1  model accepts vector.
- `out_data`  in  OUT_DIM*OUT_W  model result.
- `out_valid`  in  1  result valid.
- `out_ready`  out  1  block accepts result.
- `res_data`  out  OUT_DIM*OUT_W  captured result.
- `res_valid`  out  1  result available downstream.
- `res_ready`  in  1  downstream accepts result.
- `busy`  out  1  high in any state except IDLE and DONE.
- `done`  out  1  high in DONE.
- `sentinel_hit`  out  1  the run ended on the sentinel; cleared on `start`.
- `vec_count`  out  32  vectors completed in the current run.

## Operation
- States: IDLE, FETCH, ISSUE, COLLECT, EMIT, DONE.
- IDLE:
  - `start` loads `mem_addr` = START_ADDR, clears `vec_count` and `sentinel_hit`, then goes to FETCH.
- FETCH (one cycle):
  - If entry 0 of `mem_data` is all ones, set `sentinel_hit` and go to DONE.
  - Otherwise register `mem_data` into `in_data` and go to ISSUE.
- ISSUE:
  - `in_valid` = 1, and `in_data` holds stable.
  - On `in_valid && in_ready`, go to COLLECT.
- COLLECT:
  - `out_ready` = 1.
  - On `out_valid`, register `out_data` into `res_data` and go to EMIT.
- EMIT:
  - `res_valid` = 1, and `res_data` holds stable.
  - On `res_ready`, increment `vec_count` and `mem_addr`.
  - Then go to DONE if MAX_VECTORS ≠ 0 and the new count equals MAX_VECTORS; otherwise go to FETCH.
- DONE:
  - Hold `done`, `vec_count`, `sentinel_hit` and `res_data`.
  - `start` begins a new run exactly as from IDLE.
- Only one vector is in flight at a time. A model `out_valid` outside COLLECT is ignored.
- `abort` takes priority over every other transition:
  - next state is IDLE; `in_valid`, `out_ready` and `res_valid` drop the following cycle;
  - counters hold their values.
- `start` outside IDLE/DONE is ignored.
- `mem_addr` wraps modulo 2^ADDR_W without error.
- `vec_count` saturates at 2^32−1.

## Timing
- Reset values:
  - state IDLE;
  - `mem_addr` = START_ADDR;
  - `in_data`, `res_data`, `vec_count` all zero;
  - `in_valid`, `out_ready`, `res_valid`, `busy`, `done`, `sentinel_hit` all 0.
- All outputs are registered. The one exception is `busy`/`done`, which may be decoded from the state register.
- `start` at edge N puts the block in FETCH at N+1, and `in_valid` rises at N+2.
- With `in_ready`, `out_valid` and `res_ready` all held high:
  - a model that answers in the cycle after acceptance yields `res_valid` at N+4;
  - throughput is one vector per 4 cycles.
- Reset asserted mid-run clears everything immediately (asynchronous). No partial result is emitted.
- A sentinel at START_ADDR ends the run with `vec_count` = 0 and `sentinel_hit` = 1. No handshake occurs.
- If MAX_VECTORS and the sentinel would both apply, the count check happens first in EMIT, and the sentinel is checked only in FETCH.

## Structure
- Package `model_stream_pkg`:
  - state enum;
  - `SENTINEL_ENTRY` function returning all ones for width IN_W.
- Single module. No sub-module is needed, since the FSM, address counter and two data registers are all trivial.
- The simulation harness instantiates `memory`, `model_stream_ctrl` and `model`, prints `res_data` on each `res_valid && res_ready`, and calls `$finish` on `done`.

## Test plan
- Memory holds 3 vectors then the sentinel, MAX_VECTORS = 0, all readies high → 3 results in address order, `vec_count` = 3, `sentinel_hit` = 1, `done` = 1.
- MAX_VECTORS = 2, memory holds 5 vectors → exactly 2 results, `done` with `vec_count` = 2, `sentinel_hit` = 0, `mem_addr` = START_ADDR + 2.
- `in_ready` low for 5 cycles, then `res_ready` low for 3 cycles → `in_data` and `res_data` are stable throughout, with no duplicated or lost vectors.
- Sentinel at START_ADDR → `done` 2 cycles after `start`, `vec_count` = 0, `in_valid` never asserted.
- `abort` during COLLECT → IDLE next cycle, `out_ready` = 0; a later `start` restarts at START_ADDR with `vec_count` = 0.
- `reset` pulsed low during ISSUE → all outputs at reset values within the same cycle; a later `start` produces a correct first result.
